crypto_mem_resp: RTL

CRYPTO_MEM_RESP -- requirements
Module: crypto_mem_resp

---
 rtl/crypto_mem_pkg.sv | 18 +
 rtl/crypto_mem_resp_if.sv | 34 +++
 rtl/crypto_mem_array.sv | 34 +++
 rtl/crypto_mem_resp.sv | 139 +++++++++++++
 4 files changed

// File: rtl/crypto_mem_pkg.sv
// Shared widths, host FSM state type and counter helper for the crypto memory
// response block.
package crypto_mem_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [0:0] {
        StIdle,
        StGnt
    } host_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/crypto_mem_resp_if.sv
// Engine port, host port and counter signals of crypto_mem_resp.
interface crypto_mem_resp_if;
    import crypto_mem_pkg::*;

    logic              RdEn;
    logic [ADDR_W-1:0] RdAddr;
    logic [DATA_W-1:0] RdData;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              HostReq;
    logic              HostWe;
    logic [ADDR_W-1:0] HostAddr;
    logic [DATA_W-1:0] HostWData;
    logic              HostGnt;
    logic [DATA_W-1:0] HostRData;
    logic              HostRValid;
    logic              CntClr;
    logic [CNT_W-1:0]  RdCnt;
    logic [CNT_W-1:0]  WrCnt;

    modport master (
        output RdEn, RdAddr, WrEn, WrAddr, WrData,
        output HostReq, HostWe, HostAddr, HostWData, CntClr,
        input  RdData, HostGnt, HostRData, HostRValid, RdCnt, WrCnt
    );

    modport slave (
        input  RdEn, RdAddr, WrEn, WrAddr, WrData,
        input  HostReq, HostWe, HostAddr, HostWData, CntClr,
        output RdData, HostGnt, HostRData, HostRValid, RdCnt, WrCnt
    );

endinterface

// File: rtl/crypto_mem_array.sv
// Plain 1-write / 1-read synchronous RAM with a one-cycle registered read.
// No reset: contents survive rst_n.
module crypto_mem_array
    import crypto_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-before-write on a same-address collision; the caller forwards.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i[IDX_W-1:0]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/crypto_mem_resp.sv
// Engine/host shared memory: engine has absolute priority, host is granted only in
// engine-idle cycles, with write-first forwarding and a 1- or 2-cycle read pipeline.
module crypto_mem_resp
    import crypto_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned RD_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    crypto_mem_resp_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    logic              wr_oob, rd_oob, host_oob;
    logic              host_gnt, host_wr, host_rd;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic [DATA_W-1:0] eng_res, host_res;

    host_state_e       state_q, state_d;
    logic              eng_v_q, eng_v_d;
    logic              eng_fwd_q, eng_fwd_d;
    logic              eng_oob_q, eng_oob_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              host_v_q, host_v_d;
    logic              host_oob_q, host_oob_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    assign wr_oob   = {1'b0, bus.WrAddr} >= DEPTH_LIM;
    assign rd_oob   = {1'b0, bus.RdAddr} >= DEPTH_LIM;
    assign host_oob = {1'b0, bus.HostAddr} >= DEPTH_LIM;

    always_comb begin
        host_gnt  = (state_q == StIdle) && bus.HostReq && !bus.RdEn && !bus.WrEn;
        host_wr   = host_gnt && bus.HostWe;
        host_rd   = host_gnt && !bus.HostWe;
        // Engine and host never collide on a port: a grant implies an idle engine.
        ram_we    = (bus.WrEn && !wr_oob) || (host_wr && !host_oob);
        ram_waddr = bus.WrEn ? bus.WrAddr : bus.HostAddr;
        ram_wdata = bus.WrEn ? bus.WrData : bus.HostWData;
        ram_re    = (bus.RdEn && !rd_oob) || (host_rd && !host_oob);
        ram_raddr = bus.RdEn ? bus.RdAddr : bus.HostAddr;
    end

    crypto_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .re_i   (ram_re),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle:  state_d = host_gnt ? StGnt : StIdle;
            StGnt:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        eng_v_d    = bus.RdEn;
        eng_oob_d  = rd_oob;
        eng_fwd_d  = bus.RdEn && bus.WrEn && (bus.WrAddr == bus.RdAddr);
        fwd_data_d = eng_fwd_d ? bus.WrData : fwd_data_q;
        host_v_d   = host_rd;
        host_oob_d = host_oob;

        eng_res  = eng_oob_q ? '0 : (eng_fwd_q ? fwd_data_q : ram_rdata);
        host_res = host_oob_q ? '0 : ram_rdata;

        rd_data_d    = eng_v_q ? eng_res : rd_data_q;
        host_rdata_d = host_v_q ? host_res : host_rdata_q;

        rd_cnt_d = bus.CntClr ? '0 : (bus.RdEn ? sat_inc(rd_cnt_q) : rd_cnt_q);
        wr_cnt_d = bus.CntClr ? '0 : (bus.WrEn ? sat_inc(wr_cnt_q) : wr_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            eng_v_q      <= 1'b0;
            eng_fwd_q    <= 1'b0;
            eng_oob_q    <= 1'b0;
            fwd_data_q   <= '0;
            host_v_q     <= 1'b0;
            host_oob_q   <= 1'b0;
            rd_data_q    <= '0;
            host_rdata_q <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            eng_v_q      <= eng_v_d;
            eng_fwd_q    <= eng_fwd_d;
            eng_oob_q    <= eng_oob_d;
            fwd_data_q   <= fwd_data_d;
            host_v_q     <= host_v_d;
            host_oob_q   <= host_oob_d;
            rd_data_q    <= rd_data_d;
            host_rdata_q <= host_rdata_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    // RD_LAT=1 presents the RAM result in its arrival cycle; RD_LAT=2 one cycle later.
    if (RD_LAT == 2) begin : g_lat2
        logic host_v2_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                host_v2_q <= 1'b0;
            end else begin
                host_v2_q <= host_v_q;
            end
        end
        assign bus.RdData     = rd_data_q;
        assign bus.HostRData  = host_rdata_q;
        assign bus.HostRValid = host_v2_q;
    end else begin : g_lat1
        assign bus.RdData     = rd_data_d;
        assign bus.HostRData  = host_rdata_d;
        assign bus.HostRValid = host_v_q;
    end

    assign bus.HostGnt = host_gnt;
    assign bus.RdCnt   = rd_cnt_q;
    assign bus.WrCnt   = wr_cnt_q;

endmodule
